// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the 5-stage MIPS pipeline.
//
// Captures the decode-stage outputs in the ID/EX pipeline register on every
// rising clock edge and computes the ALU result combinationally from the
// registered operands. Memory and write-back controls are forwarded to the
// memory stage.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   cu_*               decoded controls (write enable, load, store, ALU op,
//                      shift-amount select, immediate select)
//   id_inA / id_inB    forwarded rs / rt values
//   id_imm             extended immediate
//   id_destR           destination register number
//   ID_ins_type/number instruction type and sequence tags
//   ex_wreg/m2reg/wmem registered controls to the memory stage
//   ex_destR           registered destination
//   ex_aluR            ALU result; also the EX forwarding source for decode
//   ex_inB             registered rt value (store data)
//   ex_zero            ex_aluR == 0
//   EX_ins_type/number registered tags
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cu_wreg,
    input  logic             cu_m2reg,
    input  logic             cu_wmem,
    input  logic [3:0]       cu_aluc,
    input  logic             cu_shift,
    input  logic             cu_aluimm,
    input  logic [WIDTH-1:0] id_inA,
    input  logic [WIDTH-1:0] id_inB,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_destR,
    input  logic [3:0]       ID_ins_type,
    input  logic [3:0]       ID_ins_number,
    output logic             ex_wreg,
    output logic             ex_m2reg,
    output logic             ex_wmem,
    output logic [4:0]       ex_destR,
    output logic [WIDTH-1:0] ex_aluR,
    output logic [WIDTH-1:0] ex_inB,
    output logic             ex_zero,
    output logic [3:0]       EX_ins_type,
    output logic [3:0]       EX_ins_number
);

    localparam logic [3:0] INST_TYPE_NONE = 4'd0;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1011;

    logic             wreg_p0;
    logic             m2reg_p0;
    logic             wmem_p0;
    logic [3:0]       aluc_p0;
    logic             shift_p0;
    logic             aluimm_p0;
    logic [WIDTH-1:0] ina_p0;
    logic [WIDTH-1:0] inb_p0;
    logic [WIDTH-1:0] imm_p0;
    logic [4:0]       dest_p0;
    logic [3:0]       type_p0;
    logic [3:0]       num_p0;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // 32-bit ALU; results wrap, no overflow trap. Only a[4:0] is used as
    // the shift amount so a shamt of 0 passes b through unchanged.
    function automatic logic [WIDTH-1:0] alu(input logic [3:0]       op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [4:0]              sh;
        logic [WIDTH-1:0]        r;
        sa = $signed(a);
        sb = $signed(b);
        sh = a[4:0];
        r  = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            ALU_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  r = b << sh;
            ALU_SRL:  r = b >> sh;
            ALU_SRA:  r = $unsigned(sb >>> sh);
            ALU_LUI:  r = {b[15:0], {(WIDTH-16){1'b0}}};
            default:  r = '0;
        endcase
        return r;
    endfunction

    // ID/EX register: unconditional capture; reset wins and clears every
    // field so no write enable survives an abandoned instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            wreg_p0   <= 1'b0;
            m2reg_p0  <= 1'b0;
            wmem_p0   <= 1'b0;
            aluc_p0   <= 4'b0;
            shift_p0  <= 1'b0;
            aluimm_p0 <= 1'b0;
            ina_p0    <= '0;
            inb_p0    <= '0;
            imm_p0    <= '0;
            dest_p0   <= 5'b0;
            type_p0   <= INST_TYPE_NONE;
            num_p0    <= 4'b0;
        end else begin
            wreg_p0   <= cu_wreg;
            m2reg_p0  <= cu_m2reg;
            wmem_p0   <= cu_wmem;
            aluc_p0   <= cu_aluc;
            shift_p0  <= cu_shift;
            aluimm_p0 <= cu_aluimm;
            ina_p0    <= id_inA;
            inb_p0    <= id_inB;
            imm_p0    <= id_imm;
            dest_p0   <= id_destR;
            type_p0   <= ID_ins_type;
            num_p0    <= ID_ins_number;
        end
    end

    // Execute: combinational from the ID/EX register so decode can forward
    // the result one cycle after issue.
    assign op_a = shift_p0  ? {{(WIDTH-5){1'b0}}, imm_p0[10:6]} : ina_p0;
    assign op_b = aluimm_p0 ? imm_p0 : inb_p0;

    assign ex_aluR       = alu(aluc_p0, op_a, op_b);
    assign ex_zero       = (ex_aluR == '0);
    assign ex_wreg       = wreg_p0;
    assign ex_m2reg      = m2reg_p0;
    assign ex_wmem       = wmem_p0;
    assign ex_destR      = dest_p0;
    assign ex_inB        = inb_p0;   // raw rt: store data even when aluimm=1
    assign EX_ins_type   = type_p0;
    assign EX_ins_number = num_p0;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes the hand-computed response
// of every cycle it drives; an independent monitor pops one entry after each
// rising edge and compares it with the DUT outputs.
module tb_ex_stage;

    localparam logic [3:0] NONE = 4'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cu_wreg = 0, cu_m2reg = 0, cu_wmem = 0, cu_shift = 0, cu_aluimm = 0;
    logic [3:0]  cu_aluc = 0;
    logic [31:0] id_inA = 0, id_inB = 0, id_imm = 0;
    logic [4:0]  id_destR = 0;
    logic [3:0]  ID_ins_type = 0, ID_ins_number = 0;
    logic        ex_wreg, ex_m2reg, ex_wmem, ex_zero;
    logic [4:0]  ex_destR;
    logic [31:0] ex_aluR, ex_inB;
    logic [3:0]  EX_ins_type, EX_ins_number;

    ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cu_wreg(cu_wreg), .cu_m2reg(cu_m2reg), .cu_wmem(cu_wmem),
        .cu_aluc(cu_aluc), .cu_shift(cu_shift), .cu_aluimm(cu_aluimm),
        .id_inA(id_inA), .id_inB(id_inB), .id_imm(id_imm), .id_destR(id_destR),
        .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
        .ex_destR(ex_destR), .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_zero(ex_zero),
        .EX_ins_type(EX_ins_type), .EX_ins_number(EX_ins_number)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] alu;
        logic        zero;
        logic [48:0] ctl;   // {wreg, m2reg, wmem, destR, inB, type, number}
    } exp_t;

    exp_t q[$];
    int compared   = 0;
    int mismatched = 0;

    // Monitor
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            logic [48:0] act_ctl;
            e = q.pop_front();
            compared++;
            if ({ex_aluR, ex_zero} !== {e.alu, e.zero}) begin
                mismatched++;
                $display("FAIL %s alu: got aluR=%08h zero=%0b, want aluR=%08h zero=%0b",
                         e.nm, ex_aluR, ex_zero, e.alu, e.zero);
            end
            act_ctl = {ex_wreg, ex_m2reg, ex_wmem, ex_destR, ex_inB, EX_ins_type, EX_ins_number};
            compared++;
            if (act_ctl !== e.ctl) begin
                mismatched++;
                $display("FAIL %s ctl: got %013h, want %013h", e.nm, act_ctl, e.ctl);
            end
        end
    end

    task automatic issue(input string nm, input logic wr, input logic m2, input logic wm,
                         input logic [3:0] aluc, input logic sh, input logic ai,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] dst, input logic [3:0] typ, input logic [3:0] num,
                         input logic [31:0] exp_alu);
        exp_t e;
        @(negedge clk);
        rst = 0;
        cu_wreg = wr; cu_m2reg = m2; cu_wmem = wm; cu_aluc = aluc;
        cu_shift = sh; cu_aluimm = ai;
        id_inA = a; id_inB = b; id_imm = imm; id_destR = dst;
        ID_ins_type = typ; ID_ins_number = num;
        e.nm   = nm;
        e.alu  = exp_alu;
        e.zero = (exp_alu == 32'h0);
        e.ctl  = {wr, m2, wm, dst, b, typ, num};
        q.push_back(e);
    endtask

    // Reset cycle with busy inputs: everything must read back as cleared.
    task automatic reset_cycle(input string nm);
        exp_t e;
        @(negedge clk);
        rst = 1;
        cu_wreg = 1; cu_m2reg = 1; cu_wmem = 1; cu_aluc = 4'b0011;
        cu_shift = 0; cu_aluimm = 0;
        id_inA = 32'h1234_5678; id_inB = 32'hCAFE_F00D; id_imm = 32'h55;
        id_destR = 5'd17; ID_ins_type = 4'd5; ID_ins_number = 4'd9;
        e.nm   = nm;
        e.alu  = 32'h0;
        e.zero = 1'b1;
        e.ctl  = {1'b0, 1'b0, 1'b0, 5'd0, 32'h0, NONE, 4'd0};
        q.push_back(e);
    endtask

    initial begin
        reset_cycle("reset0");
        reset_cycle("reset1");
        //     name        wr m2 wm aluc     sh ai  inA           inB           imm           dst  typ  num  expected
        issue("add_ovf",   1, 0, 0, 4'b0000, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        5'd3, 4'd1, 4'd1, 32'h80000000);
        issue("sub_neg",   1, 0, 0, 4'b0001, 0, 0, 32'd5,        32'd7,        32'h0,        5'd4, 4'd1, 4'd2, 32'hFFFFFFFE);
        issue("slt",       1, 0, 0, 4'b0110, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd5, 4'd1, 4'd3, 32'h00000001);
        issue("sltu",      1, 0, 0, 4'b0111, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd5, 4'd1, 4'd4, 32'h00000000);
        issue("sll4",      1, 0, 0, 4'b1000, 1, 0, 32'h0,        32'h80000010, 32'h00000100, 5'd6, 4'd2, 4'd5, 32'h00000100);
        issue("srl4",      1, 0, 0, 4'b1001, 1, 0, 32'h0,        32'h80000010, 32'h00000100, 5'd6, 4'd2, 4'd6, 32'h08000001);
        issue("sra4",      1, 0, 0, 4'b1010, 1, 0, 32'h0,        32'h80000010, 32'h00000100, 5'd6, 4'd2, 4'd7, 32'hF8000001);
        issue("sll0",      1, 0, 0, 4'b1000, 1, 0, 32'hFFFFFFE0, 32'h80000010, 32'h00000000, 5'd6, 4'd2, 4'd8, 32'h80000010);
        issue("sra0",      1, 0, 0, 4'b1010, 1, 0, 32'h0,        32'h80000010, 32'h00000000, 5'd6, 4'd2, 4'd9, 32'h80000010);
        issue("lui",       1, 0, 0, 4'b1011, 0, 1, 32'h0,        32'h0,        32'h00001234, 5'd7, 4'd3, 4'd10, 32'h12340000);
        issue("addi_neg",  1, 0, 0, 4'b0000, 0, 1, 32'h00000100, 32'h0,        32'hFFFFFFFC, 5'd7, 4'd3, 4'd11, 32'h000000FC);
        issue("and",       1, 0, 0, 4'b0010, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd9, 4'd1, 4'd12, 32'hF000F000);
        issue("or",        1, 0, 0, 4'b0011, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd9, 4'd1, 4'd13, 32'hFFF0FFF0);
        issue("xor",       1, 0, 0, 4'b0100, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd9, 4'd1, 4'd14, 32'h0FF00FF0);
        issue("nor",       1, 0, 0, 4'b0101, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd9, 4'd1, 4'd15, 32'h000F000F);
        issue("add_wrap",  1, 0, 0, 4'b0000, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd2, 4'd1, 4'd0, 32'h00000000);
        issue("sub_wrap",  1, 0, 0, 4'b0001, 0, 0, 32'h0,        32'h00000001, 32'h0,        5'd2, 4'd1, 4'd1, 32'hFFFFFFFF);
        issue("op1100",    1, 0, 0, 4'b1100, 0, 0, 32'd5,        32'd3,        32'h0,        5'd2, 4'd1, 4'd2, 32'h00000000);
        issue("op1111",    1, 0, 0, 4'b1111, 0, 0, 32'd5,        32'd3,        32'h0,        5'd2, 4'd1, 4'd3, 32'h00000000);
        issue("jal",       1, 0, 0, 4'b0000, 0, 0, 32'h00400010, 32'h0,        32'h0,        5'd31, 4'd4, 4'd4, 32'h00400010);
        issue("lw",        1, 1, 0, 4'b0000, 0, 1, 32'h00002000, 32'h0,        32'h00000010, 5'd10, 4'd5, 4'd5, 32'h00002010);
        // bubble pass-through
        issue("bub_add",   1, 0, 0, 4'b0000, 0, 0, 32'd1,        32'd2,        32'h0,        5'd8, 4'd1, 4'd6, 32'd3);
        issue("bubble",    0, 0, 0, 4'b0000, 0, 0, 32'h0,        32'h0,        32'h0,        5'd0, NONE, 4'd7, 32'h0);
        issue("bub_or",    1, 0, 0, 4'b0011, 0, 0, 32'h0000000F, 32'h000000F0, 32'h0,        5'd8, 4'd1, 4'd8, 32'h000000FF);
        // back-to-back forwarding source
        issue("b2b_add",   1, 0, 0, 4'b0000, 0, 0, 32'd10,       32'd20,       32'h0,        5'd11, 4'd1, 4'd9, 32'd30);
        issue("b2b_sub",   1, 0, 0, 4'b0001, 0, 0, 32'd30,       32'd8,        32'h0,        5'd12, 4'd1, 4'd10, 32'd22);
        // store data is raw rt even with aluimm
        issue("sw",        0, 0, 1, 4'b0000, 0, 1, 32'h00001000, 32'hDEADBEEF, 32'h00000008, 5'd0, 4'd6, 4'd11, 32'h00001008);
        issue("sw2",       0, 0, 1, 4'b0000, 0, 1, 32'h00001000, 32'h0BADF00D, 32'h0000000C, 5'd0, 4'd6, 4'd12, 32'h0000100C);
        reset_cycle("rst_mid");
        issue("post_rst",  1, 0, 0, 4'b0000, 0, 0, 32'd100,      32'd23,       32'h0,        5'd13, 4'd1, 4'd13, 32'd123);

        @(negedge clk);
        cu_wreg = 0; cu_m2reg = 0; cu_wmem = 0; cu_aluc = 0; cu_shift = 0; cu_aluimm = 0;
        ID_ins_type = NONE;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d entries pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
